// File: rtl/config_readback_pkg.sv
// ------------------------------------------------------------------------
// config_readback_pkg : shared state encoding and frame constants | Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package config_readback_pkg;

   localparam int         CFG_FRAME_HDR_BYTES = 4;
   localparam logic [7:0] CFG_SYNC_BYTE0      = 8'h5A;
   localparam logic [7:0] CFG_SYNC_BYTE1      = 8'hA5;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_SYNC0  = 4'd1,
      ST_SYNC1  = 4'd2,
      ST_CNT_HI = 4'd3,
      ST_CNT_LO = 4'd4,
      ST_LOAD   = 4'd5,
      ST_DATA   = 4'd6,
      ST_CSUM   = 4'd7,
      ST_DONE   = 4'd8
   } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/word_byte_serializer.sv
// ------------------------------------------------------------------------
// word_byte_serializer : 32-bit word to MSB-first byte shifter | Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module word_byte_serializer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] word,
   input  logic        shift_en,
   output logic [7:0]  byte_out,
   output logic        last_byte
);

   logic [31:0] shift_reg;
   logic [1:0]  byte_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= 32'h0;
         byte_idx  <= 2'd0;
      end else if (load) begin
         shift_reg <= word;
         byte_idx  <= 2'd0;
      end else if (shift_en) begin
         shift_reg <= {shift_reg[23:0], 8'h00};
         byte_idx  <= byte_idx + 2'd1;
      end
   end

   assign byte_out  = shift_reg[31:24];
   assign last_byte = (byte_idx == 2'd3);

endmodule

`default_nettype wire

// File: rtl/config_readback_tx.sv
// ------------------------------------------------------------------------
// config_readback_tx : frames readback words (sync, count, data, XOR csum)
// onto the CDC IN byte stream | Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module config_readback_tx
   import config_readback_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE0  = CFG_SYNC_BYTE0,
   parameter logic [7:0] SYNC_BYTE1  = CFG_SYNC_BYTE1,
   parameter int         COUNT_WIDTH = 16
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   start_i,
   input  logic [COUNT_WIDTH-1:0] word_count_i,
   input  logic [31:0]            word_data_i,
   input  logic                   word_valid_i,
   output logic                   word_ready_o,
   output logic [7:0]             in_data_o,
   output logic                   in_valid_o,
   input  logic                   in_ready_i,
   output logic                   busy_o,
   output logic                   done_o
);

   tx_state_e              state;
   tx_state_e              next_state;
   logic [COUNT_WIDTH-1:0] remaining;
   logic [7:0]             checksum;
   logic [15:0]            count_hdr;
   logic                   byte_xfer;
   logic                   word_load;
   logic                   ser_shift;
   logic [7:0]             ser_byte;
   logic                   ser_last;

   // The header is sent before any decrement, so remaining doubles as the count.
   assign count_hdr = 16'(remaining);
   assign byte_xfer = in_valid_o & in_ready_i;
   assign word_load = (state == ST_LOAD) & word_valid_i;
   assign ser_shift = (state == ST_DATA) & byte_xfer;

   word_byte_serializer u_serializer (
      .clk       (clk_i),
      .rst_n     (reset_n_i),
      .load      (word_load),
      .word      (word_data_i),
      .shift_en  (ser_shift),
      .byte_out  (ser_byte),
      .last_byte (ser_last)
   );

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         remaining <= '0;
         checksum  <= 8'h00;
      end else begin
         if ((state == ST_IDLE) && start_i) begin
            remaining <= word_count_i;
            checksum  <= 8'h00;
         end
         if (byte_xfer && ((state == ST_CNT_HI) || (state == ST_CNT_LO) || (state == ST_DATA))) begin
            checksum <= checksum ^ in_data_o;
         end
         if (ser_shift && ser_last && (remaining != '0)) begin
            remaining <= remaining - COUNT_WIDTH'(1);
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:   if (start_i)   next_state = ST_SYNC0;
         ST_SYNC0:  if (byte_xfer) next_state = ST_SYNC1;
         ST_SYNC1:  if (byte_xfer) next_state = ST_CNT_HI;
         ST_CNT_HI: if (byte_xfer) next_state = ST_CNT_LO;
         ST_CNT_LO: if (byte_xfer) next_state = (remaining != '0) ? ST_LOAD : ST_CSUM;
         ST_LOAD:   if (word_valid_i) next_state = ST_DATA;
         ST_DATA: begin
            // remaining is non-zero here; a value above one means more words follow
            if (byte_xfer && ser_last) begin
               next_state = (remaining > COUNT_WIDTH'(1)) ? ST_LOAD : ST_CSUM;
            end
         end
         ST_CSUM:   if (byte_xfer) next_state = ST_DONE;
         ST_DONE:   next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      in_valid_o   = 1'b0;
      in_data_o    = 8'h00;
      word_ready_o = 1'b0;
      done_o       = 1'b0;
      busy_o       = (state != ST_IDLE);
      case (state)
         ST_SYNC0:  begin in_valid_o = 1'b1; in_data_o = SYNC_BYTE0;      end
         ST_SYNC1:  begin in_valid_o = 1'b1; in_data_o = SYNC_BYTE1;      end
         ST_CNT_HI: begin in_valid_o = 1'b1; in_data_o = count_hdr[15:8]; end
         ST_CNT_LO: begin in_valid_o = 1'b1; in_data_o = count_hdr[7:0];  end
         ST_DATA:   begin in_valid_o = 1'b1; in_data_o = ser_byte;        end
         ST_CSUM:   begin in_valid_o = 1'b1; in_data_o = checksum;        end
         ST_LOAD:   word_ready_o = 1'b1;
         ST_DONE:   done_o = 1'b1;
         default:   ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_config_readback_tx.sv
// ------------------------------------------------------------------------
// tb_config_readback_tx : randomized scoreboard bench for config_readback_tx
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_config_readback_tx;

   localparam logic [7:0] SYNC0 = 8'h5A;
   localparam logic [7:0] SYNC1 = 8'hA5;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] word_count = 16'h0;
   logic [31:0] word_data = 32'h0;
   logic        word_valid = 1'b0;
   logic        word_ready;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready = 1'b0;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   config_readback_tx #(
      .SYNC_BYTE0  (8'h5A),
      .SYNC_BYTE1  (8'hA5),
      .COUNT_WIDTH (16)
   ) dut (
      .clk_i        (clk),
      .reset_n_i    (reset_n),
      .start_i      (start),
      .word_count_i (word_count),
      .word_data_i  (word_data),
      .word_valid_i (word_valid),
      .word_ready_o (word_ready),
      .in_data_o    (in_data),
      .in_valid_o   (in_valid),
      .in_ready_i   (in_ready),
      .busy_o       (busy),
      .done_o       (done)
   );

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q[$];
   logic [31:0] word_q[$];
   logic [31:0] frame_words[$];
   int          cyc = 0;
   int          rdy_pct = 100;
   int          wv_pct = 100;
   int          done_cnt = 0;
   int          bytes_seen = 0;
   int          sync_cyc = 0;
   int          csum_cyc = 0;
   bit          wr_seen = 1'b0;
   bit          prev_stall = 1'b0;
   logic [7:0]  prev_data = 8'h00;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference frame: sync pair, big-endian count, words MSB-first, XOR of all non-sync bytes.
   function automatic void build_frame();
      logic [15:0] c16;
      logic [7:0]  cs;
      logic [7:0]  b;
      logic [31:0] w;
      c16 = 16'(frame_words.size());
      exp_q.push_back(SYNC0);
      exp_q.push_back(SYNC1);
      exp_q.push_back(c16[15:8]);
      exp_q.push_back(c16[7:0]);
      cs = c16[15:8] ^ c16[7:0];
      foreach (frame_words[i]) begin
         w = frame_words[i];
         for (int k = 3; k >= 0; k--) begin
            b = w[8*k +: 8];
            exp_q.push_back(b);
            cs = cs ^ b;
         end
      end
      exp_q.push_back(cs);
   endfunction

   // Monitor / scoreboard
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev_stall = 1'b0;
            continue;
         end
         if (prev_stall) begin
            check("stall_valid_held", {31'b0, in_valid}, 32'd1);
            check("stall_data_held", {24'b0, in_data}, {24'b0, prev_data});
         end
         if (word_ready) begin
            wr_seen = 1'b1;
            check("valid_low_in_load", {31'b0, in_valid}, 32'd0);
         end
         if (in_valid && in_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_byte", {24'b0, in_data}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("byte", {24'b0, in_data}, {24'b0, e});
               if (bytes_seen == 0) sync_cyc = cyc;
               bytes_seen++;
               if (exp_q.size() == 0) csum_cyc = cyc;
            end
         end
         prev_stall = in_valid && !in_ready;
         prev_data  = in_data;
         if (done) begin
            done_cnt++;
            check("done_after_csum", exp_q.size(), 32'd0);
            check("busy_at_done", {31'b0, busy}, 32'd1);
         end
      end
   end

   // Sink and word-source drivers
   initial begin
      bit wx;
      forever begin
         @(negedge clk);
         wx = word_valid && word_ready;
         @(posedge clk);
         #1;
         if (wx && word_q.size() > 0) void'(word_q.pop_front());
         in_ready = ($urandom_range(99) < rdy_pct);
         if (word_q.size() > 0 && $urandom_range(99) < wv_pct) begin
            word_valid = 1'b1;
            word_data  = word_q[0];
         end else begin
            word_valid = 1'b0;
            word_data  = $urandom;
         end
      end
   end

   task automatic pulse_start(input logic [15:0] cnt);
      @(posedge clk);
      #1;
      start = 1'b1;
      word_count = cnt;
      @(posedge clk);
      #1;
      start = 1'b0;
      word_count = 16'($urandom);
   endtask

   task automatic do_frame(input int rpct, input int wpct, input bit starve,
                           input bit spurious, input bit span);
      int cnt;
      int d0;
      int t;
      cnt = frame_words.size();
      d0 = done_cnt;
      rdy_pct = rpct;
      wv_pct = wpct;
      wr_seen = 1'b0;
      bytes_seen = 0;
      build_frame();
      if (!starve) foreach (frame_words[i]) word_q.push_back(frame_words[i]);
      pulse_start(16'(cnt));
      check("busy_after_start", {31'b0, busy}, 32'd1);
      check("sync0_after_start", {23'b0, in_valid, in_data}, {23'b0, 1'b1, SYNC0});
      if (starve) begin
         t = 0;
         while (!word_ready && t < 200) begin @(negedge clk); t++; end
         check("reach_load", {31'b0, word_ready}, 32'd1);
         repeat (20) begin
            @(negedge clk);
            check("starve_valid_low", {31'b0, in_valid}, 32'd0);
            check("starve_busy", {31'b0, busy}, 32'd1);
         end
         foreach (frame_words[i]) word_q.push_back(frame_words[i]);
      end
      if (spurious) begin
         t = 0;
         while (bytes_seen < 6 && t < 500) begin @(negedge clk); t++; end
         check("reach_data", {31'b0, bytes_seen >= 6}, 32'd1);
         pulse_start(16'($urandom));
      end
      t = 0;
      while (done_cnt == d0 && t < 2000) begin @(negedge clk); t++; end
      repeat (3) @(negedge clk);
      check("done_pulses", done_cnt - d0, 32'd1);
      check("frame_consumed", exp_q.size(), 32'd0);
      check("idle_busy_low", {31'b0, busy}, 32'd0);
      if (cnt == 0) check("no_word_ready", {31'b0, wr_seen}, 32'd0);
      if (span) check("span_cycles", csum_cyc - sync_cyc + 1, 4 + 5 * cnt + 1);
      exp_q.delete();
      word_q.delete();
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_data", {24'b0, in_data}, 32'd0);
      check("rst_in_valid", {31'b0, in_valid}, 32'd0);
      check("rst_word_ready", {31'b0, word_ready}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (2) @(posedge clk);

      frame_words = '{32'h12345678};
      do_frame(100, 100, 1'b0, 1'b0, 1'b1);

      frame_words.delete();
      do_frame(100, 100, 1'b0, 1'b0, 1'b1);

      frame_words = '{32'hDEADBEEF, 32'h00000001};
      do_frame(50, 100, 1'b0, 1'b0, 1'b0);

      frame_words = '{32'hA1B2C3D4};
      do_frame(100, 100, 1'b1, 1'b0, 1'b0);

      frame_words = '{32'h0F1E2D3C, 32'h4B5A6978};
      do_frame(100, 100, 1'b0, 1'b1, 1'b1);

      // Abort mid-frame: with a free sink the second data byte is on the bus 6 cycles after SYNC0.
      frame_words = '{32'hCAFEF00D};
      rdy_pct = 100;
      wv_pct = 100;
      word_q.push_back(32'hCAFEF00D);
      build_frame();
      bytes_seen = 0;
      pulse_start(16'd1);
      repeat (6) @(posedge clk);
      #2;
      check("pre_reset_data1", {23'b0, in_valid, in_data}, {23'b0, 1'b1, 8'hFE});
      reset_n = 1'b0;
      exp_q.delete();
      word_q.delete();
      @(negedge clk);
      check("abort_in_data", {24'b0, in_data}, 32'd0);
      check("abort_in_valid", {31'b0, in_valid}, 32'd0);
      check("abort_word_ready", {31'b0, word_ready}, 32'd0);
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_done", {31'b0, done}, 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      frame_words = '{32'h89ABCDEF};
      do_frame(100, 100, 1'b0, 1'b0, 1'b1);

      for (int n = 0; n < 8; n++) begin
         frame_words.delete();
         for (int i = 0; i < int'($urandom_range(4)); i++) frame_words.push_back($urandom);
         do_frame(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), 1'b0, 1'b0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
